// File: rtl/enemy_wave_scheduler_if.sv
// Bus between the wave scheduler and the game/enemy side.
// Signalling: every control input and output is either a level or a
// single-cycle pulse, qualified only by the clock edge. There is no
// back-pressure. startOfFrame, start, spawn, killPulse and waveCleared are
// one-cycle pulses. killCount is meaningful only while killPulse is high.
// pause, hit, alive, wave, enemySpeed, gameWon and fsmState are levels.
interface enemy_wave_scheduler_if;
    logic       startOfFrame;
    logic       start;
    logic       pause;
    logic [3:0] hit;
    logic [3:0] spawn;
    logic [3:0] alive;
    logic [2:0] wave;
    logic [7:0] enemySpeed;
    logic       killPulse;
    logic [2:0] killCount;
    logic       waveCleared;
    logic       gameWon;
    logic [2:0] fsmState;

    // Scheduler side
    modport master (
        input  startOfFrame, start, pause, hit,
        output spawn, alive, wave, enemySpeed, killPulse, killCount,
               waveCleared, gameWon, fsmState
    );

    // Game-state / enemy side
    modport slave (
        output startOfFrame, start, pause, hit,
        input  spawn, alive, wave, enemySpeed, killPulse, killCount,
               waveCleared, gameWon, fsmState
    );
endinterface

// File: rtl/enemy_wave_scheduler.sv
// Enemy wave scheduler: spawns up to four enemy slots per wave at a fixed
// frame cadence, tracks which slots are alive from collision reports and
// steps through waves with increasing horizontal speed.
module enemy_wave_scheduler #(
    parameter int SPAWN_INTERVAL = 32,
    parameter int GAP_FRAMES     = 60,
    parameter int MAX_WAVES      = 5,
    parameter int BASE_SPEED     = 80,
    parameter int SPEED_STEP     = 20
) (
    input logic                    clk,
    input logic                    resetN,
    enemy_wave_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SPAWN    = 3'd1,
        ACTIVE   = 3'd2,
        WAVE_GAP = 3'd3,
        DONE     = 3'd4
    } state_t;

    // The frame counter serves both the spawn cadence and the inter-wave gap.
    localparam int MAX_FRAMES = (SPAWN_INTERVAL > GAP_FRAMES) ? SPAWN_INTERVAL : GAP_FRAMES;
    localparam int CNT_W      = ($clog2(MAX_FRAMES) > 6) ? $clog2(MAX_FRAMES) : 6;

    localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(SPAWN_INTERVAL - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_FRAMES - 1);
    localparam logic [2:0]       LAST_WAVE  = 3'(MAX_WAVES);
    localparam logic [7:0]       IDLE_SPEED = 8'(BASE_SPEED);

    // Per-wave speed, saturating at the 8-bit ceiling; only called with w >= 1.
    function automatic logic [7:0] speedFor(input logic [2:0] w);
        int s;
        s = BASE_SPEED + (int'(w) - 1) * SPEED_STEP;
        if (s > 255) s = 255;
        if (s < 0)   s = 0;
        return 8'(s);
    endfunction

    // Wave n spawns n+1 enemies, capped by the four available slots.
    function automatic logic [2:0] spawnCountFor(input logic [2:0] w);
        return (w >= 3'd3) ? 3'd4 : (w + 3'd1);
    endfunction

    state_t           state,        stateNxt;
    logic [CNT_W-1:0] frameCnt,     frameCntNxt;
    logic [1:0]       nextSlot,     nextSlotNxt;
    logic [2:0]       toSpawn,      toSpawnNxt;
    logic [3:0]       aliveR,       aliveNxt;
    logic [2:0]       waveR,        waveNxt;
    logic [7:0]       speedR,       speedNxt;
    logic [3:0]       spawnR,       spawnNxt;
    logic             killPulseR,   killPulseNxt;
    logic [2:0]       killCountR,   killCountNxt;
    logic             waveClearedR, waveClearedNxt;
    logic [3:0]       spawnMask;
    logic [3:0]       killMask;

    // State and output registers; reset wins over everything, including pause.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state        <= IDLE;
            frameCnt     <= '0;
            nextSlot     <= '0;
            toSpawn      <= '0;
            aliveR       <= '0;
            waveR        <= '0;
            speedR       <= IDLE_SPEED;
            spawnR       <= '0;
            killPulseR   <= 1'b0;
            killCountR   <= '0;
            waveClearedR <= 1'b0;
        end else begin
            state        <= stateNxt;
            frameCnt     <= frameCntNxt;
            nextSlot     <= nextSlotNxt;
            toSpawn      <= toSpawnNxt;
            aliveR       <= aliveNxt;
            waveR        <= waveNxt;
            speedR       <= speedNxt;
            spawnR       <= spawnNxt;
            killPulseR   <= killPulseNxt;
            killCountR   <= killCountNxt;
            waveClearedR <= waveClearedNxt;
        end
    end

    // Next-state logic: wave sequencing, spawn cadence and hit processing.
    always_comb begin
        stateNxt       = state;
        frameCntNxt    = frameCnt;
        nextSlotNxt    = nextSlot;
        toSpawnNxt     = toSpawn;
        aliveNxt       = aliveR;
        waveNxt        = waveR;
        speedNxt       = speedR;
        waveClearedNxt = 1'b0;
        spawnMask      = 4'b0000;
        killMask       = 4'b0000;

        // Pause freezes everything; pulses simply stay low.
        if (!bus.pause) begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        stateNxt    = SPAWN;
                        waveNxt     = 3'd1;
                        speedNxt    = speedFor(3'd1);
                        toSpawnNxt  = spawnCountFor(3'd1);
                        nextSlotNxt = 2'd0;
                        frameCntNxt = SPAWN_LAST;
                        aliveNxt    = 4'b0000;
                    end
                end

                SPAWN: begin
                    if (bus.startOfFrame) begin
                        if (frameCnt == SPAWN_LAST) begin
                            spawnMask   = 4'b0001 << nextSlot;
                            nextSlotNxt = nextSlot + 2'd1;
                            toSpawnNxt  = toSpawn - 3'd1;
                            frameCntNxt = '0;
                            if (toSpawn == 3'd1) begin
                                stateNxt = ACTIVE;
                            end
                        end else begin
                            frameCntNxt = frameCnt + CNT_W'(1);
                        end
                    end
                    // A slot being spawned this cycle is never killed by a hit.
                    killMask = bus.hit & aliveR & ~spawnMask;
                end

                ACTIVE: begin
                    if (aliveR == 4'b0000) begin
                        waveClearedNxt = 1'b1;
                        if (waveR == LAST_WAVE) begin
                            stateNxt = DONE;
                        end else begin
                            stateNxt    = WAVE_GAP;
                            frameCntNxt = '0;
                        end
                    end else begin
                        killMask = bus.hit & aliveR;
                    end
                end

                WAVE_GAP: begin
                    if (bus.startOfFrame) begin
                        if (frameCnt == GAP_LAST) begin
                            stateNxt    = SPAWN;
                            waveNxt     = waveR + 3'd1;
                            speedNxt    = speedFor(waveR + 3'd1);
                            toSpawnNxt  = spawnCountFor(waveR + 3'd1);
                            nextSlotNxt = 2'd0;
                            frameCntNxt = SPAWN_LAST;
                        end else begin
                            frameCntNxt = frameCnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    stateNxt = IDLE;
                end
            endcase
        end

        aliveNxt     = (aliveNxt & ~killMask) | spawnMask;
        spawnNxt     = spawnMask;
        killPulseNxt = |killMask;
        killCountNxt = {2'b00, killMask[0]} + {2'b00, killMask[1]}
                     + {2'b00, killMask[2]} + {2'b00, killMask[3]};
    end

    assign bus.spawn       = spawnR;
    assign bus.alive       = aliveR;
    assign bus.wave        = waveR;
    assign bus.enemySpeed  = speedR;
    assign bus.killPulse   = killPulseR;
    assign bus.killCount   = killCountR;
    assign bus.waveCleared = waveClearedR;
    assign bus.gameWon     = (state == DONE);
    assign bus.fsmState    = state;

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Self-checking bench for enemy_wave_scheduler: directed game scenarios
// followed by randomized stimulus, all checked against a frame-countdown
// model of the wave rules.
module tb_enemy_wave_scheduler;

    localparam int SI    = 4;
    localparam int GAP   = 5;
    localparam int MAXW  = 5;
    localparam int BASE  = 80;
    localparam int STEP  = 20;

    localparam int P_IDLE   = 0;
    localparam int P_SPAWN  = 1;
    localparam int P_ACTIVE = 2;
    localparam int P_GAP    = 3;
    localparam int P_DONE   = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetN = 1'b1;
    always #5 clk = ~clk;

    enemy_wave_scheduler_if bus();

    enemy_wave_scheduler #(
        .SPAWN_INTERVAL(SI),
        .GAP_FRAMES    (GAP),
        .MAX_WAVES     (MAXW),
        .BASE_SPEED    (BASE),
        .SPEED_STEP    (STEP)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus.master)
    );

    // ---------------- scoreboard ----------------
    int assertCount = 0;
    int failCount   = 0;
    logic [3:0] exp_q[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         mPhase = P_IDLE;
    int         mWave = 0;
    int         mFramesLeft = 0;   // frames still to see before the next event
    int         mSpawnsLeft = 0;
    int         mSlot = 0;
    logic [3:0] mAlive = 4'b0000;
    logic [3:0] eSpawn = 4'b0000;
    int         eKill = 0;
    logic       eCleared = 1'b0;

    function automatic int speedOf(input int w);
        int v;
        if (w == 0) return BASE;
        v = BASE + (w - 1) * STEP;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic enterWave(input int w);
        mPhase      = P_SPAWN;
        mWave       = w;
        mSpawnsLeft = (w + 1 > 4) ? 4 : w + 1;
        mSlot       = 0;
        mFramesLeft = 1;
    endtask

    task automatic modelStep(input logic rst, input logic sof, input logic st,
                             input logic ps, input logic [3:0] h);
        logic [3:0] killed;
        logic [3:0] born;
        killed   = 4'b0000;
        born     = 4'b0000;
        eSpawn   = 4'b0000;
        eKill    = 0;
        eCleared = 1'b0;
        if (rst) begin
            mPhase = P_IDLE;
            mWave  = 0;
            mAlive = 4'b0000;
            mSlot  = 0;
            return;
        end
        if (ps) return;
        case (mPhase)
            P_IDLE, P_DONE: begin
                if (st) begin
                    enterWave(1);
                    mAlive = 4'b0000;
                end
            end
            P_SPAWN: begin
                if (sof) begin
                    mFramesLeft--;
                    if (mFramesLeft == 0) begin
                        born = 4'(1 << mSlot);
                        mSlot++;
                        mSpawnsLeft--;
                        mFramesLeft = SI;
                        if (mSpawnsLeft == 0) mPhase = P_ACTIVE;
                    end
                end
                killed = h & mAlive & ~born;
            end
            P_ACTIVE: begin
                if (mAlive == 4'b0000) begin
                    eCleared = 1'b1;
                    if (mWave == MAXW) begin
                        mPhase = P_DONE;
                    end else begin
                        mPhase      = P_GAP;
                        mFramesLeft = GAP;
                    end
                end else begin
                    killed = h & mAlive;
                end
            end
            P_GAP: begin
                if (sof) begin
                    mFramesLeft--;
                    if (mFramesLeft == 0) enterWave(mWave + 1);
                end
            end
            default: ;
        endcase
        mAlive = (mAlive & ~killed) | born;
        eKill  = $countones(killed);
        eSpawn = born;
        if (born != 4'b0000) exp_q.push_back(born);
    endtask

    // ---------------- driver ----------------
    task automatic checkOutputs();
        checkVal("spawn",       bus.spawn,       eSpawn);
        checkVal("alive",       bus.alive,       mAlive);
        checkVal("wave",        bus.wave,        mWave);
        checkVal("enemySpeed",  bus.enemySpeed,  speedOf(mWave));
        checkVal("killPulse",   bus.killPulse,   eKill != 0);
        if (eKill != 0) checkVal("killCount", bus.killCount, eKill);
        checkVal("waveCleared", bus.waveCleared, eCleared);
        checkVal("gameWon",     bus.gameWon,     mPhase == P_DONE);
        if (bus.spawn != 4'b0000) begin
            if (exp_q.size() == 0) checkVal("spawnUnexpected", bus.spawn, 0);
            else                   checkVal("spawnOrder", bus.spawn, exp_q.pop_front());
        end
    endtask

    task automatic cycle(input logic rst, input logic sof, input logic st,
                         input logic ps, input logic [3:0] h);
        resetN           = rst;
        bus.startOfFrame = sof;
        bus.start        = st;
        bus.pause        = ps;
        bus.hit          = h;
        modelStep(rst, sof, st, ps, h);
        @(posedge clk);
        #1;
        checkOutputs();
    endtask

    // One free-running step: a frame every other cycle, optionally killing
    // everything once a wave has finished spawning.
    task automatic stepFree(input int i, input bit killAll);
        cycle(1'b0, (i % 2) == 0, 1'b0, 1'b0,
              (killAll && mPhase == P_ACTIVE) ? 4'hF : 4'h0);
    endtask

    task automatic runUntil(input int phase, input int wantWave, input bit killAll,
                            input string tag);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (mPhase == phase && mWave == wantWave) begin
                reached = 1'b1;
                break;
            end
            stepFree(i, killAll);
        end
        checkVal(tag, reached, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.startOfFrame = 1'b0;
        bus.start        = 1'b0;
        bus.pause        = 1'b0;
        bus.hit          = 4'b0000;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
        checkVal("resetSpeed", bus.enemySpeed, 8'd80);
        checkVal("resetWave", bus.wave, 3'd0);

        // Wave 1: two spawns, four frames apart
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        runUntil(P_ACTIVE, 1, 1'b0, "reachWave1Active");
        checkVal("wave1Alive", bus.alive, 4'b0011);
        checkVal("wave1Speed", bus.enemySpeed, 8'd80);

        // Hits under pause and hits on dead slots are ignored
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
        checkVal("pausedHitAlive", bus.alive, 4'b0011);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
        checkVal("deadHitPulse", bus.killPulse, 1'b0);

        // start ignored while active
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        checkVal("startInActive", bus.wave, 3'd1);

        // Double kill, then wave cleared
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0011);
        checkVal("doubleKillCount", bus.killCount, 3'd2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        checkVal("wave1Cleared", bus.waveCleared, 1'b1);

        // Gap, then wave 2
        runUntil(P_SPAWN, 2, 1'b0, "reachWave2");
        checkVal("wave2Speed", bus.enemySpeed, 8'd100);

        // Spawn of slot 1 together with a hit on slots 0 and 1
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (mPhase == P_SPAWN && mSlot == 1 && mFramesLeft == 1) begin
                    found = 1'b1;
                    break;
                end
                cycle(1'b0, (i % 2) == 0, 1'b0, 1'b0, 4'h0);
            end
            checkVal("reachSlot1Spawn", found, 1'b1);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b0011);
        checkVal("spawnWinsAlive", bus.alive[1], 1'b1);
        checkVal("spawnWinsKillCount", bus.killCount, 3'd1);

        // Through to wave 5
        runUntil(P_ACTIVE, 5, 1'b1, "reachWave5Active");
        checkVal("wave5Alive", bus.alive, 4'hF);
        checkVal("wave5Speed", bus.enemySpeed, 8'd160);
        runUntil(P_DONE, 5, 1'b1, "reachDone");
        checkVal("finalCleared", bus.waveCleared, 1'b1);
        checkVal("gameWonHigh", bus.gameWon, 1'b1);

        // Restart from DONE
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        checkVal("restartWave", bus.wave, 3'd1);
        checkVal("restartWon", bus.gameWon, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkVal("restartSpawn", bus.spawn, 4'b0001);

        // Reset in the middle of wave 3 spawning with alive = 0101
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                if (mPhase == P_SPAWN && mWave == 3 && mSlot == 3) begin
                    found = 1'b1;
                    break;
                end
                stepFree(i, 1'b1);
            end
            checkVal("reachWave3Slot3", found, 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
        checkVal("midSpawnAlive", bus.alive, 4'b0101);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checkVal("midResetAlive", bus.alive, 4'b0000);
        checkVal("midResetSpeed", bus.enemySpeed, 8'd80);

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            logic rst, sof, st, ps;
            logic [3:0] h;
            rst = ($urandom_range(0, 499) == 0);
            sof = ($urandom_range(0, 2) == 0);
            st  = ($urandom_range(0, 39) == 0);
            ps  = ($urandom_range(0, 7) == 0);
            h   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cycle(rst, sof, st, ps, h);
        end

        checkVal("spawnQueueEmpty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
